dmem_responder: RTL
===================

# dmem_responder

Data-memory responder at the far end of the memory stage's `mem_read_req` / `mem_write_req` interface. It accepts one read or write per transaction and applies byte-lane strobes derived from size and address. After a parameterised number of wait states it returns read data with a one-cycle `data_ok` pulse, and holds `busy` high so the hazard unit stalls the pipeline until the response arrives. It sits between the CPU memory stage and a word-organised on-chip data array owned by this block.

## Interface
- `DEPTH_WORDS`, 1024, number of 32-bit words in the array; power of two.
- `WAIT_CYCLES`, 1, wait states between acceptance and response; legal range 0–15.

- `clk`  in  1  clock; everything is sampled on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mread`  in  mem_read_req  fields: `valid` (1), `addr` (32), `size` (3).
- `mwrite`  in  mem_write_req  fields: `valid` (1), `addr` (32), `size` (3), `data` (32, already lane-shifted by the initiator).
- `rd`  out  32  full read word; lanes are not extended or shifted.
- `data_ok`  out  1  response pulse for the current transaction.
- `busy`  out  1  stall request to the hazard unit.
- `misalign`  out  1  high with `data_ok` when the completed request was misaligned.

## Operation
- Size encoding: 0 = byte, 1 = half, 2 = word. Values above 2 are treated as word.
- FSM states:
  - IDLE: if `mwrite.valid` or `mread.valid` is high, capture kind, addr, size and data, load the counter with `WAIT_CYCLES`, and go to WAIT. If `WAIT_CYCLES`=0, go straight to RESP.
  - WAIT: decrement the counter. When it reaches 1, go to RESP.
  - RESP: assert `data_ok`, then return to IDLE.
- Simultaneous `mwrite.valid` and `mread.valid` in IDLE: the write wins and the read is dropped.
- Byte strobes:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'hF`
- Misaligned requests are half with `addr[0]`=1, or word with `addr[1:0]`≠0. They perform no array access, return `rd`=0, and assert `misalign` with `data_ok`.
- Array index is `addr[2 +: log2(DEPTH_WORDS)]`. Higher address bits are ignored, so the address space wraps modulo the depth.
- Write: strobed lanes of the captured data are committed on the rising edge that ends the RESP cycle. Unstrobed lanes are unchanged.
- Read: `rd` is loaded from the array on the edge entering RESP and held until the next response.
- `rd` is 0 in write responses.

## Timing
- Reset values: state IDLE, counter 0, `rd`=0, `data_ok`=0, `misalign`=0. Array contents are not reset.
- `busy` is combinational:
  - high in an IDLE cycle with any valid request;
  - high in every WAIT cycle;
  - low in RESP, so the pipeline advances on the same edge that completes the transaction.
- Latency: a request accepted in cycle T produces `data_ok` in cycle T+WAIT_CYCLES+1.
- Initiator contract: hold the request stable while `busy`=1. The block uses only the values captured at acceptance.
- Requests present during RESP are ignored. The next acceptance happens at the earliest in the cycle after RESP, so back-to-back transactions complete every WAIT_CYCLES+2 cycles.
- `data_ok` is exactly one cycle wide and never asserts without a preceding acceptance.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. No write is committed unless its RESP-ending edge has already occurred, and no `data_ok` is emitted for the aborted request.

## Test plan
- WAIT_CYCLES=1: write word 0x12345678 to 0x40, then read 0x40.
  - `data_ok` at T+2 for both transactions; `busy` high for 2 cycles per transaction; `rd`=0x12345678.
- Byte write of `mwrite.data`=0x00AB0000 at 0x42 over word 0xFFFFFFFF, then word read.
  - `rd`=0xFFABFFFF.
- Half write at 0x41.
  - `data_ok` with `misalign`=1 and `rd`=0; the array word at 0x40 is unchanged.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: a read accepted at T.
  - `data_ok` at T+1 and T+4 respectively; `busy` low in the `data_ok` cycle.
- Reset pulsed during WAIT of a word write to 0x80.
  - No `data_ok`; a later read of 0x80 returns the previous contents; all outputs 0 during reset.
- `mread.valid` and `mwrite.valid` high together (write 0x5A5A5A5A to 0x10, read 0x20).
  - The write is performed and the response has `rd`=0. A DEPTH_WORDS-aliased address (0x10 + 4·DEPTH_WORDS) reads back 0x5A5A5A5A.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one read or write per transaction, byte-lane strobes,
// WAIT_CYCLES wait states, and a one-cycle data_ok pulse. busy stalls the pipeline meanwhile.
package dmem_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
    } mem_read_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } mem_write_req;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_read_req  mread,
    input  mem_write_req mwrite,
    output logic [31:0]  rd,
    output logic         data_ok,
    output logic         busy,
    output logic         misalign,
    output state_t       fsm_state
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int LA = AW + 2;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          write_q, mis_q;
    logic [LA-1:0] addr_q;
    logic [2:0]    size_q;
    logic [31:0]   data_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req_any, accept, cur_write, cur_mis;
    logic [LA-1:0] cur_addr;
    logic [2:0]    cur_size;
    logic [3:0]    strobe_q;
    logic          unused_addr_hi;

    function automatic logic misaligned(input logic [1:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    // Handshake: a request is taken when valid is high in an IDLE cycle; the initiator holds it
    // while busy=1, and completion is signalled by the single-cycle data_ok pulse.
    assign req_any = mwrite.valid | mread.valid;
    assign accept  = (state == S_IDLE) && req_any;

    // In IDLE the live request (write wins) is used so WAIT_CYCLES=0 can respond next cycle.
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_size  = size_q;
        if (state == S_IDLE) begin
            cur_write = mwrite.valid;
            cur_addr  = mwrite.valid ? mwrite.addr[LA-1:0] : mread.addr[LA-1:0];
            cur_size  = mwrite.valid ? mwrite.size : mread.size;
        end
    end

    assign cur_mis        = misaligned(cur_addr[1:0], cur_size);
    assign strobe_q       = lanes(addr_q[1:0], size_q);
    assign unused_addr_hi = ^{mread.addr[31:LA], mwrite.addr[31:LA]};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = S_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rd      <= 32'd0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            data_q  <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                write_q <= mwrite.valid;
                mis_q   <= cur_mis;
                addr_q  <= cur_addr;
                size_q  <= cur_size;
                data_q  <= mwrite.data;
            end
            if (state_next == S_RESP) begin
                rd <= (!cur_write && !cur_mis) ? mem[cur_addr[LA-1:2]] : 32'd0;
            end
        end
    end

    // The commit edge is the one ending RESP; an async reset drops state first, aborting it.
    always_ff @(posedge clk) begin
        if (state == S_RESP && write_q && !mis_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe_q[i]) mem[addr_q[LA-1:2]][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

    assign data_ok   = (state == S_RESP);
    assign misalign  = (state == S_RESP) && mis_q;
    assign busy      = !reset && (((state == S_IDLE) && req_any) || (state == S_WAIT));
    assign fsm_state = state;
endmodule
